// File: rtl/chunk_adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
//   state_t        : control FSM state encoding
//   DEFAULT_WIDTH  : default operand/result width
//   DEFAULT_CHUNK  : default bits processed per cycle
package chunk_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_add_slice.sv
// Combinational CHUNK-bit adder slice, reused every cycle by the top.
// Ports:
//   a, b      : CHUNK-bit operand chunks
//   cin       : carry into the chunk LSB
//   s         : CHUNK-bit chunk sum
//   cout      : carry out of the chunk MSB
//   c_msb_in  : carry into the chunk MSB (for signed overflow)
module chunk_add_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s      = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];

    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recoverable from it.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// Chunk-serial add/subtract: captures A, B and mode, adds CHUNK bits per
// cycle through one shared slice, then presents the result until taken.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, sub            : operands, 0 = A+B, 1 = A-B
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, carry, overflow : registered result, carry out of MSB, signed overflow
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned N          = WIDTH / CHUNK_SAFE;
    localparam int unsigned KW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    // Elaboration guard on illegal sizing.
    generate
        if ((CHUNK == 0) || ((WIDTH % CHUNK_SAFE) != 0) || (WIDTH < 2)) begin : g_bad_params
            $error("chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic             w_c_msb_in;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_k == K_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next = BUSY;
            BUSY:    if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Select chunk k of the captured operands.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_add_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a        (w_a_chunk),
        .b        (w_b_chunk),
        .cin      (r_c),
        .s        (w_s),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Operand capture and chunk-by-chunk accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction as A + ~B + 1.
            r_a <= a;
            r_b <= sub ? ~b : b;
            r_c <= sub;
            r_k <= '0;
        end else if (r_state == BUSY) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (r_k == KW'(i)) begin
                    r_sum[i*CHUNK +: CHUNK] <= w_s;
                end
            end
            r_c <= w_cout;
            r_k <= r_k + KW'(1);
            if (w_last) begin
                r_carry <= w_cout;
                r_ovf   <= w_c_msb_in ^ w_cout;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_chunk_adder.sv
module tb_chunk_adder;

    localparam int unsigned W16 = 16;
    localparam int unsigned N16 = 4;
    localparam int unsigned W8  = 8;
    localparam int unsigned N8  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, iv16, ir16, sub16, ov16, or16, c16, o16;
    logic [15:0] a16, b16, sum16;
    logic        rst8, iv8, ir8, sub8, ov8, or8, c8, o8;
    logic [7:0]  a8, b8, sum8;

    int n_checks = 0;
    int n_errors = 0;

    chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .carry(c16), .overflow(o16)
    );

    chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .carry(c8), .overflow(o8)
    );

    // Reference: plain integer arithmetic, signed overflow from operand/result signs.
    function automatic logic [17:0] ref_op(input int unsigned w, input logic [15:0] av,
                                           input logic [15:0] bv, input logic sb);
        int unsigned mask, be, full, s;
        logic sa, sbs, ss, c, o;
        mask = (32'd1 << w) - 32'd1;
        be   = sb ? ((~{16'd0, bv}) & mask) : {16'd0, bv};
        full = {16'd0, av} + be + {31'd0, sb};
        s    = full & mask;
        c    = ((full >> w) & 32'd1) != 0;
        sa   = av[w-1];
        sbs  = bv[w-1];
        ss   = ((s >> (w - 1)) & 32'd1) != 0;
        o    = sb ? ((sa != sbs) && (ss != sa)) : ((sa == sbs) && (ss != sa));
        return {o, c, 16'(s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w8, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic sb, input logic ordy);
        if (w8) begin
            iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sb; or8 = ordy;
        end else begin
            iv16 = v; a16 = av; b16 = bv; sub16 = sb; or16 = ordy;
        end
    endtask

    task automatic sample(input bit w8, output logic ir, output logic ov,
                          output logic [15:0] s, output logic c, output logic o);
        if (w8) begin
            ir = ir8; ov = ov8; s = {8'd0, sum8}; c = c8; o = o8;
        end else begin
            ir = ir16; ov = ov16; s = sum16; c = c16; o = o16;
        end
    endtask

    // One full transaction with latency, result, DONE-hold and return-to-IDLE checks.
    task automatic run_op(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                          input logic sb, input logic [17:0] exp, input int hold,
                          input string tag);
        int unsigned n;
        int          guard, lat;
        logic        ir, ov, c, o;
        logic [15:0] s;
        n = w8 ? N8 : N16;
        guard = 0;
        sample(w8, ir, ov, s, c, o);
        while (ir !== 1'b1 && guard < 20) begin
            tick(); guard++; sample(w8, ir, ov, s, c, o);
        end
        n_checks++;
        if (ir !== 1'b1) begin
            n_errors++; $display("FAIL %s ready_before_op: in_ready=%b required 1", tag, ir);
        end
        drive(w8, 1'b1, av, bv, sb, 1'b0);
        tick();
        // Inputs change and in_valid stays high after capture; both must be ignored.
        drive(w8, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        lat = 1;
        sample(w8, ir, ov, s, c, o);
        while (ov !== 1'b1 && lat < 20) begin
            tick(); lat++; sample(w8, ir, ov, s, c, o);
        end
        n_checks++;
        if (lat != int'(n + 1)) begin
            n_errors++; $display("FAIL %s latency: got %0d cycles required %0d", tag, lat, n + 1);
        end
        n_checks++;
        if ({o, c, s} !== exp) begin
            n_errors++;
            $display("FAIL %s result: got sum=%h c=%b ov=%b required sum=%h c=%b ov=%b",
                     tag, s, c, o, exp[15:0], exp[16], exp[17]);
        end
        for (int i = 0; i < hold; i++) begin
            drive(w8, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            tick();
            sample(w8, ir, ov, s, c, o);
            n_checks++;
            if ({ir, ov, o, c, s} !== {1'b0, 1'b1, exp}) begin
                n_errors++;
                $display("FAIL %s done_hold[%0d]: got ir=%b ov=%b sum=%h c=%b o=%b required ir=0 ov=1 sum=%h c=%b o=%b",
                         tag, i, ir, ov, s, c, o, exp[15:0], exp[16], exp[17]);
            end
        end
        drive(w8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        drive(w8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        sample(w8, ir, ov, s, c, o);
        n_checks++;
        if ({ir, ov} !== 2'b10) begin
            n_errors++; $display("FAIL %s release: got ir=%b ov=%b required ir=1 ov=0", tag, ir, ov);
        end
    endtask

    task automatic test_reset();
        logic        ir, ov, c, o;
        logic [15:0] s;
        for (int k = 0; k < 2; k++) begin
            sample(k == 1, ir, ov, s, c, o);
            n_checks++;
            if ({ir, ov, s, c, o} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL reset_state[w8=%0d]: got ir=%b ov=%b sum=%h c=%b o=%b required ir=1 ov=0 sum=0000 c=0 o=0",
                         k, ir, ov, s, c, o);
            end
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 0, "add_1234_4321");
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, 0, "add_ffff_0001");
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, 0, "add_7fff_0001");
        run_op(1'b0, 16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 0, "sub_0005_0007");
        run_op(1'b0, 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 0, "sub_8000_0001");
    endtask

    task automatic test_done_hold();
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 3, "done_hold");
    endtask

    task automatic test_reset_mid_busy();
        logic        ir, ov, c, o;
        logic [15:0] s;
        logic        seen;
        drive(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
        tick();                          // accepted; first BUSY cycle
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick();                          // second BUSY cycle
        rst16 = 1'b1;
        tick();
        rst16 = 1'b0;
        sample(1'b0, ir, ov, s, c, o);
        n_checks++;
        if ({ir, ov, s} !== {1'b1, 1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL mid_busy_reset: got ir=%b ov=%b sum=%h required ir=1 ov=0 sum=0000", ir, ov, s);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov16 === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++; $display("FAIL mid_busy_no_valid: got out_valid pulse=%b required 0", seen);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        run_op(1'b0, 16'h0F0F, 16'h0101, 1'b1, ref_op(W16, 16'h0F0F, 16'h0101, 1'b1), 0, "after_reset");
    endtask

    task automatic test_width8();
        logic [15:0] av, bv;
        logic        sb;
        run_op(1'b1, 16'h0080, 16'h0080, 1'b0, {1'b1, 1'b1, 16'h0000}, 0, "w8_80_80");
        run_op(1'b1, 16'h0010, 16'h0020, 1'b1, ref_op(W8, 16'h0010, 16'h0020, 1'b1), 1, "w8_sub");
        for (int i = 0; i < 6; i++) begin
            av = {8'd0, 8'($urandom)};
            bv = {8'd0, 8'($urandom)};
            sb = 1'($urandom);
            run_op(1'b1, av, bv, sb, ref_op(W8, av, bv, sb), int'($urandom_range(0, 2)), "w8_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av, bv;
        logic        sb;
        for (int i = 0; i < 30; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            sb = 1'($urandom);
            if (i % 5 == 0) av = 16'h8000 | av;
            run_op(1'b0, av, bv, sb, ref_op(W16, av, bv, sb), int'($urandom_range(0, 2)), "rand16");
        end
    endtask

    initial begin
        rst16 = 1'b1;
        rst8  = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst16 = 1'b0;
        rst8  = 1'b0;
        test_reset();
        test_directed();
        test_done_hold();
        test_reset_mid_busy();
        test_width8();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (>=2).
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 overflow  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-016 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-017 On in_valid && in_ready the block SHALL capture a, b_eff = sub ? ~b : b, carry-in = sub, clear chunk index to 0, and go to BUSY.
REQ-018 In BUSY, each cycle SHALL add chunk k of A, B_eff and the carry register, write chunk k of sum, update the carry register, increment k.
REQ-019 When k == N-1 is processed, the FSM SHALL go to DONE on that edge; BUSY lasts exactly N cycles.
REQ-020 Latency: handshake in cycle t -> out_valid high from cycle t+N+1.
REQ-021 carry SHALL be the carry out of bit WIDTH-1; overflow SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-022 sum, carry, overflow SHALL be registered and held stable while out_valid is high.
REQ-023 In DONE, out_ready high SHALL return the FSM to IDLE on that edge; out_ready low SHALL hold DONE indefinitely.
REQ-024 in_valid outside IDLE SHALL be ignored; changes of a, b, sub after capture SHALL not affect the result.
REQ-025 CHUNK == WIDTH SHALL be legal (N = 1, BUSY one cycle).
REQ-026 No back-to-back overlap: a new operation is accepted no earlier than the cycle after the DONE handshake.

Reset
REQ-027 rst high at a rising edge SHALL force IDLE, clear sum, carry, overflow, carry register and chunk index to 0, in any state.
REQ-028 Reset mid-BUSY or in DONE SHALL discard the operation; no out_valid pulse follows.
REQ-029 In the first cycle after rst deasserts: in_ready = 1, out_valid = 0, sum = 0.

Structure
REQ-030 A shared package chunk_adder_pkg SHALL hold the state enum type and the default WIDTH/CHUNK constants.
REQ-031 One sub-module, chunk_add_slice (combinational CHUNK-bit adder: a, b, cin -> s, cout, c_msb_in), SHALL be instantiated once and reused every cycle.
REQ-032 A static elaboration check SHALL reject WIDTH % CHUNK != 0 or CHUNK < 1.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-033 0x1234 + 0x4321, sub=0, accept in cycle t -> out_valid at t+5, sum=0x5555, carry=0, overflow=0.
REQ-034 0xFFFF + 0x0001 -> sum=0x0000, carry=1, overflow=0; 0x7FFF + 0x0001 -> sum=0x8000, carry=0, overflow=1.
REQ-035 sub: 0x0005 - 0x0007 -> sum=0xFFFE, carry=0, overflow=0; 0x8000 - 0x0001 -> sum=0x7FFF, carry=1, overflow=1.
REQ-036 out_ready low for 3 cycles in DONE, a/b/in_valid toggled meanwhile -> sum/flags stable, in_ready=0, no second operation accepted; out_ready high -> IDLE next cycle.
REQ-037 rst pulsed in 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, sum=0; new operation then completes correctly.
REQ-038 WIDTH=8, CHUNK=8: 0x80 + 0x80 -> out_valid at t+2, sum=0x00, carry=1, overflow=1.
